// File: rtl/uart_tx.sv
// UART transmitter with a byte FIFO: 8 data bits, LSB first, one stop bit, idle high.
// Define UART_TX_PARITY_EN to insert an even-parity bit after bit 7 (11-bit frames).
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [7:0]                    i_data,
    input  logic                          i_valid,
    output logic                          o_ready,
    output logic                          o_tx,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

    localparam int unsigned AW     = $clog2(FIFO_DEPTH);
    localparam logic [15:0] BitMax = 16'(CLKS_PER_BIT - 1);
    localparam logic [AW:0] Full   = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_TX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          ready_q;
    logic          push, pop, fifo_empty;
    logic [7:0]    head;

    state_e        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          tx_q, tx_d;
    logic          bit_end, load_frame;
`ifdef UART_TX_PARITY_EN
    logic          parity_q, parity_d;
`endif

    assign push       = i_valid & ready_q & ~i_rst;
    assign fifo_empty = (count_q == '0);
    assign head       = mem[rd_ptr_q];
    assign count_d    = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
    assign bit_end    = (cnt_q == '0);

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr_q] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            // Registered from next-state count so ready never lags a pop or a fill.
            ready_q <= (count_d != Full);
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shreg_d    = shreg_q;
        tx_d       = tx_q;
        pop        = 1'b0;
        load_frame = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (!fifo_empty) load_frame = 1'b1;
            end
            StStart: begin
                if (bit_end) begin
                    cnt_d   = BitMax;
                    idx_d   = 3'd0;
                    tx_d    = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StData: begin
                if (bit_end) begin
                    cnt_d = BitMax;
                    if (idx_q == 3'd7) begin
                        idx_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = StParity;
`else
                        tx_d    = 1'b1;
                        state_d = StStop;
`endif
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        tx_d    = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (bit_end) begin
                    cnt_d   = BitMax;
                    tx_d    = 1'b1;
                    state_d = StStop;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`endif
            StStop: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        load_frame = 1'b1;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = StIdle;
            end
        endcase

        // Shared by IDLE and the end of STOP so back-to-back frames have no gap.
        if (load_frame) begin
            pop     = 1'b1;
            shreg_d = head;
            cnt_d   = BitMax;
            idx_d   = 3'd0;
            tx_d    = 1'b0;
            state_d = StStart;
`ifdef UART_TX_PARITY_EN
            parity_d = ^head;
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            idx_q    <= '0;
            shreg_q  <= '0;
            tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shreg_q  <= shreg_d;
            tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign o_ready      = ready_q;
    assign o_tx         = tx_q;
    assign o_busy       = (state_q != StIdle) | (count_q != '0);
    assign o_fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Follows UART_TX_PARITY_EN so the same bench covers both frame formats.
module tb_uart_tx;

    localparam int Cpb   = 4;
    localparam int Depth = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FL = 11;
`else
    localparam int FL = 10;
`endif
    localparam int FrameCyc = FL * Cpb;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] data = 8'h00;
    logic       ready, tx, busy;
    logic [2:0] fifo_count;

    uart_tx #(
        .CLKS_PER_BIT(Cpb),
        .FIFO_DEPTH  (Depth)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_data      (data),
        .i_valid     (valid),
        .o_ready     (ready),
        .o_tx        (tx),
        .o_busy      (busy),
        .o_fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  d;
        logic [10:0] frame;  // bit 0 = start, sent first
    } vec_t;

    vec_t       vecs[5];
    int         total = 0;
    int         bad = 0;
    logic       sbuf[$];
    logic [7:0] got[$];
    int         starts[$];
    logic       rdy, acc;
    int         lows, busyc, stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Two reset edges; the first also offers a push that must be ignored.
    task automatic do_reset();
        rst   = 1'b1;
        valid = 1'b1;
        data  = 8'hEE;
        tick();
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Capture o_tx starting with the current sample.
    task automatic record(input int n);
        sbuf.delete();
        sbuf.push_back(tx);
        for (int k = 1; k < n; k++) begin
            tick();
            sbuf.push_back(tx);
        end
    endtask

    // Independent receiver: find a start bit, sample each bit mid-period.
    task automatic decode();
        logic [7:0] b;
        int i;
        got.delete();
        starts.delete();
        i = 0;
        while (i + FrameCyc <= sbuf.size()) begin
            if (sbuf[i] == 1'b0) begin
                for (int k = 0; k < 8; k++) b[k] = sbuf[i + Cpb * (k + 1) + 2];
`ifdef UART_TX_PARITY_EN
                chk("rx_parity", 32'(sbuf[i + Cpb * 9 + 2]), 32'(^b));
`endif
                chk("rx_stop", 32'(sbuf[i + Cpb * (FL - 1) + 2]), 32'd1);
                got.push_back(b);
                starts.push_back(i);
                i += FrameCyc;
            end else begin
                i++;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef UART_TX_PARITY_EN
        vecs[0] = '{8'h55, 11'b1_0_01010101_0};
        vecs[1] = '{8'h07, 11'b1_1_00000111_0};
        vecs[2] = '{8'h03, 11'b1_0_00000011_0};
        vecs[3] = '{8'h80, 11'b1_1_10000000_0};
        vecs[4] = '{8'hFF, 11'b1_0_11111111_0};
`else
        vecs[0] = '{8'h55, 11'b0_1_01010101_0};
        vecs[1] = '{8'h07, 11'b0_1_00000111_0};
        vecs[2] = '{8'h03, 11'b0_1_00000011_0};
        vecs[3] = '{8'h80, 11'b0_1_10000000_0};
        vecs[4] = '{8'hFF, 11'b0_1_11111111_0};
`endif

        do_reset();

        // Single frames, checked cycle by cycle.
        for (int v = 0; v < 5; v++) begin
            chk($sformatf("v%0d_idle_tx", v), 32'(tx), 32'd1);
            chk($sformatf("v%0d_idle_busy", v), 32'(busy), 32'd0);
            valid = 1'b1;
            data  = vecs[v].d;
            tick();
            valid = 1'b0;
            chk($sformatf("v%0d_count_after_push", v), 32'(fifo_count), 32'd1);
            chk($sformatf("v%0d_tx_accept_edge", v), 32'(tx), 32'd1);
            chk($sformatf("v%0d_busy_accept_edge", v), 32'(busy), 32'd1);
            for (int b = 0; b < FL; b++) begin
                for (int c = 0; c < Cpb; c++) begin
                    tick();
                    chk($sformatf("v%0d_bit%0d_cyc%0d", v, b, c), 32'(tx),
                        32'(vecs[v].frame[b]));
                end
            end
            chk($sformatf("v%0d_busy_last", v), 32'(busy), 32'd1);
            tick();
            chk($sformatf("v%0d_busy_end", v), 32'(busy), 32'd0);
            chk($sformatf("v%0d_tx_end", v), 32'(tx), 32'd1);
            chk($sformatf("v%0d_ready_end", v), 32'(ready), 32'd1);
        end

        // Back-to-back: second start immediately follows the first stop.
        do_reset();
        valid = 1'b1;
        data  = 8'hA5;
        tick();
        data = 8'h3C;
        tick();
        valid = 1'b0;
        record(2 * FrameCyc + 8);
        decode();
        chk("b2b_frames", 32'(got.size()), 32'd2);
        if (got.size() >= 2) begin
            chk("b2b_byte0", 32'(got[0]), 32'hA5);
            chk("b2b_byte1", 32'(got[1]), 32'h3C);
            chk("b2b_start0", 32'(starts[0]), 32'd0);
            chk("b2b_start1", 32'(starts[1]), 32'(FrameCyc));
        end

        // Saturate the FIFO with an incrementing stream.
        do_reset();
        valid = 1'b1;
        data  = 8'h00;
        rdy   = ready;
        stall = 0;
        sbuf.delete();
        for (int cyc = 0; cyc < 6 * FrameCyc + 20; cyc++) begin
            @(posedge clk);
            acc = rdy;
            #1;
            if (acc) data = data + 8'd1;
            sbuf.push_back(tx);
            rdy = ready;
            if (!ready && fifo_count != 3'd4) stall++;
            if (cyc == 3) chk("fill_count3", 32'(fifo_count), 32'd3);
            if (cyc == 4) begin
                chk("fill_count4", 32'(fifo_count), 32'd4);
                chk("fill_ready_low", 32'(ready), 32'd0);
                chk("fill_accepted5", 32'(data), 32'd5);
            end
        end
        valid = 1'b0;
        chk("fill_ready_stall", 32'(stall), 32'd0);
        chk("fill_accepted_total", 32'(data), 32'd11);
        decode();
        chk("fill_frames", 32'(got.size()), 32'd6);
        for (int k = 0; k < got.size(); k++) begin
            chk($sformatf("fill_byte%0d", k), 32'(got[k]), 32'(k));
            if (k > 0) chk($sformatf("fill_gap%0d", k), 32'(starts[k] - starts[k-1]),
                           32'(FrameCyc));
        end

        // Reset during data bit 3 of 0xFF with two more bytes queued.
        do_reset();
        valid = 1'b1;
        data  = 8'hFF;
        tick();
        data = 8'h11;
        tick();
        data = 8'h22;
        tick();
        valid = 1'b0;
        repeat (15) tick();
        chk("abort_pre_count", 32'(fifo_count), 32'd2);
        chk("abort_pre_busy", 32'(busy), 32'd1);
        chk("abort_pre_tx_bit3", 32'(tx), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_tx", 32'(tx), 32'd1);
        chk("abort_count", 32'(fifo_count), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(ready), 32'd1);
        lows  = 0;
        busyc = 0;
        repeat (100) begin
            tick();
            if (tx !== 1'b1) lows++;
            if (busy !== 1'b0) busyc++;
        end
        chk("abort_no_frames", 32'(lows), 32'd0);
        chk("abort_stays_idle", 32'(busyc), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, i_clk cycles per serial bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 16, transmit FIFO entries; power of two, 2..256.
REQ-003 i_clk  input  1  sole clock; all logic on rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_data  input  8  byte to transmit, sampled when i_valid and o_ready are both high.
REQ-006 i_valid  input  1  producer has a byte on i_data.
REQ-007 o_ready  output  1  FIFO can accept a byte this cycle.
REQ-008 o_tx  output  1  serial line, idle high, LSB first, registered output.
REQ-009 o_busy  output  1  FIFO non-empty or frame in progress.
REQ-010 o_fifo_count  output  $clog2(FIFO_DEPTH)+1  number of bytes currently held in the FIFO.

Function
REQ-011 A byte shall be pushed on a rising edge where i_valid=1 and o_ready=1; i_valid while o_ready=0 shall be ignored and produce no push.
REQ-012 o_ready shall be the registered complement of FIFO-full; it does not depend combinationally on i_valid or on a same-cycle pop.
REQ-013 FSM states: IDLE, START, DATA, PARITY (only when the parity feature is compiled in), STOP.
REQ-014 IDLE -> START on the first edge where the FIFO is non-empty; the head byte shall be popped into a shift register on that edge and o_tx driven 0.
REQ-015 With an empty FIFO and an idle FSM, o_tx shall go low exactly 1 cycle after the accepting edge (the start bit begins at edge N+1 for a push at edge N).
REQ-016 Each bit (start, 8 data, parity, stop) shall hold o_tx for exactly CLKS_PER_BIT cycles, timed by a down-counter reloaded with CLKS_PER_BIT-1 at each bit boundary.
REQ-017 DATA shall shift out bit0 first; a 3-bit index advances at each bit boundary; DATA exits after bit7.
REQ-018 STOP drives o_tx=1 for one bit time; at its end the FSM goes to START with a new pop if the FIFO is non-empty (no idle gap), else to IDLE.
REQ-019 Simultaneous push and pop in one cycle shall leave o_fifo_count unchanged and lose no data; FIFO pointers wrap modulo FIFO_DEPTH.
REQ-020 A push into a full FIFO is impossible (o_ready=0); a pop from an empty FIFO shall never occur.
REQ-021 o_busy = (state != IDLE) | (o_fifo_count != 0), registered or combinational from registers only.

Reset
REQ-022 On an edge with i_rst=1: state=IDLE, o_tx=1, FIFO pointers and o_fifo_count=0, o_ready=1, o_busy=0, bit counter and index=0.
REQ-023 Reset asserted mid-frame shall abort the frame immediately (o_tx=1 on the next cycle) and discard all FIFO contents; no partial frame resumes after release.
REQ-024 Pushes are ignored during any cycle with i_rst=1.

Configuration
REQ-025 Macro UART_TX_PARITY_EN: when defined, a PARITY state follows bit7 and transmits even parity (XOR of the 8 data bits) for one bit time, giving 11-bit frames; when undefined, DATA goes directly to STOP, giving 10-bit frames, and no parity logic is present.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4 unless stated)
REQ-026 Reset then push 0x55 at edge N -> o_tx low from N+1 for 4 cycles, then 1,0,1,0,1,0,1,0 (4 cycles each), then high for 4 cycles; o_busy falls after the stop bit; 40 cycles total.
REQ-027 Push 0xA5, 0x3C back-to-back -> second start bit begins on the cycle immediately after the first stop bit ends; decoded bytes are 0xA5 then 0x3C.
REQ-028 Hold i_valid=1 with incrementing data 0x00.. from reset -> o_ready drops once o_fifo_count reaches 4 and rises within 1 cycle of each pop; the serial stream carries 0x00,0x01,... with no loss or duplication.
REQ-029 Assert i_rst for 1 cycle during data bit 3 of 0xFF with 2 bytes queued -> o_tx=1 on the next cycle, o_fifo_count=0, o_busy=0; no further frames are emitted.
REQ-030 With UART_TX_PARITY_EN defined, send 0x07 -> parity bit=1 and a 44-cycle frame; send 0x03 -> parity bit=0; without the macro, 0x07 produces a 40-cycle frame.
